// File: rtl/frac_baud_generator.sv
// Fractional baud / oversample tick generator.
// Produces an oversample tick whose average period is div_int + div_frac/2^NB_FRAC
// clock cycles, plus a bit-rate tick every OVERSAMPLE ticks. New divisors are staged
// in a shadow register and applied only at safe points so the tick stream never glitches.
module frac_baud_generator #(
    parameter int NB_DIV       = 16,
    parameter int NB_FRAC      = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_DIV  = 651,
    parameter int DEFAULT_FRAC = 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_enable,
    input  logic                          i_load,
    input  logic [NB_DIV-1:0]             i_div_int,
    input  logic [NB_FRAC-1:0]            i_div_frac,
    input  logic                          i_sync,
    output logic                          o_tick,
    output logic                          o_bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] o_tick_idx,
    output logic                          o_cfg_pending,
    output logic                          o_cfg_err
);

    localparam int                NB_IDX   = $clog2(OVERSAMPLE);
    localparam logic [NB_IDX-1:0] IDX_LAST = NB_IDX'(OVERSAMPLE - 1);

    // Active and shadow divisor state
    logic [NB_DIV-1:0]  r_div_int_act;
    logic [NB_FRAC-1:0] r_div_frac_act;
    logic [NB_DIV-1:0]  r_div_int_shd;
    logic [NB_FRAC-1:0] r_div_frac_shd;
    logic               r_pending;
    logic               r_cfg_err;

    // Phase state
    logic [NB_DIV-1:0]  r_counter;
    logic [NB_FRAC-1:0] r_acc;
    logic               r_carry;
    logic [NB_IDX-1:0]  r_idx;
    logic               r_tick;
    logic               r_bit_tick;

    // Derived combinational values
    logic [NB_DIV:0]    w_period;
    logic [NB_DIV:0]    w_period_m1;
    logic               w_terminal;
    logic [NB_FRAC:0]   w_acc_sum;
    logic               w_apply;
    logic               w_load_ok;

    // Interval length, terminal detection, fractional accumulation and the apply condition
    always_comb begin
        w_period    = {1'b0, r_div_int_act} + {{NB_DIV{1'b0}}, r_carry};
        w_period_m1 = w_period - (NB_DIV + 1)'(1);
        w_terminal  = ({1'b0, r_counter} == w_period_m1);
        w_acc_sum   = {1'b0, r_acc} + {1'b0, r_div_frac_act};
        w_apply     = r_pending & (i_sync | ~i_enable | w_terminal);
        w_load_ok   = (i_div_int >= NB_DIV'(2));
    end

    // Shadow capture, validation and promotion of the shadow divisor to active
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div_int_act  <= NB_DIV'(DEFAULT_DIV);
            r_div_frac_act <= NB_FRAC'(DEFAULT_FRAC);
            r_div_int_shd  <= NB_DIV'(DEFAULT_DIV);
            r_div_frac_shd <= NB_FRAC'(DEFAULT_FRAC);
            r_pending      <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            if (w_apply) begin
                r_div_int_act  <= r_div_int_shd;
                r_div_frac_act <= r_div_frac_shd;
                r_pending      <= 1'b0;
            end
            if (i_load) begin
                if (w_load_ok) begin
                    r_div_int_shd  <= i_div_int;
                    r_div_frac_shd <= i_div_frac;
                    r_pending      <= 1'b1;
                    r_cfg_err      <= 1'b0;
                end else begin
                    r_cfg_err      <= 1'b1;
                end
            end
        end
    end

    // Period counter, fractional carry, tick index and tick pulse generation
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_counter  <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_tick     <= 1'b0;
            r_bit_tick <= 1'b0;
        end else if (i_sync) begin
            r_counter  <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_tick     <= 1'b0;
            r_bit_tick <= 1'b0;
        end else if (!i_enable) begin
            r_tick     <= 1'b0;
            r_bit_tick <= 1'b0;
            if (r_pending) begin
                r_counter <= '0;
                r_acc     <= '0;
                r_carry   <= 1'b0;
            end
        end else if (w_terminal) begin
            r_counter  <= '0;
            r_tick     <= 1'b1;
            r_bit_tick <= (r_idx == IDX_LAST);
            r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + NB_IDX'(1);
            if (r_pending) begin
                r_acc   <= '0;
                r_carry <= 1'b0;
            end else begin
                r_acc   <= w_acc_sum[NB_FRAC-1:0];
                r_carry <= w_acc_sum[NB_FRAC];
            end
        end else begin
            r_counter  <= r_counter + NB_DIV'(1);
            r_tick     <= 1'b0;
            r_bit_tick <= 1'b0;
        end
    end

    assign o_tick        = r_tick;
    assign o_bit_tick    = r_bit_tick;
    assign o_tick_idx    = r_idx;
    assign o_cfg_pending = r_pending;
    assign o_cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_frac_baud_generator.sv
// Testbench for frac_baud_generator: directed scenarios with literal expectations plus a
// randomized phase, all continuously compared against a cycle-level behavioural model.
module tb_frac_baud_generator;

    localparam int NB_DIV     = 16;
    localparam int NB_FRAC    = 4;
    localparam int OVERSAMPLE = 16;
    localparam int NB_IDX     = $clog2(OVERSAMPLE);

    logic              i_clk = 1'b0;
    logic              i_reset_n;
    logic              i_enable;
    logic              i_load;
    logic [NB_DIV-1:0] i_div_int;
    logic [NB_FRAC-1:0] i_div_frac;
    logic              i_sync;
    logic              o_tick;
    logic              o_bit_tick;
    logic [NB_IDX-1:0] o_tick_idx;
    logic              o_cfg_pending;
    logic              o_cfg_err;

    int total = 0;
    int bad   = 0;

    frac_baud_generator #(
        .NB_DIV(NB_DIV), .NB_FRAC(NB_FRAC), .OVERSAMPLE(OVERSAMPLE),
        .DEFAULT_DIV(651), .DEFAULT_FRAC(1)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_load(i_load),
        .i_div_int(i_div_int), .i_div_frac(i_div_frac), .i_sync(i_sync),
        .o_tick(o_tick), .o_bit_tick(o_bit_tick), .o_tick_idx(o_tick_idx),
        .o_cfg_pending(o_cfg_pending), .o_cfg_err(o_cfg_err)
    );

    // Free-running clock
    always #5 i_clk = ~i_clk;

    // Behavioural model state: divisors as integers, elapsed cycles in the interval,
    // number of ticks since the fractional phase restarted, and ticks since index restart
    int  mDiv, mFrac, sDiv, sFrac;
    bit  mPend, mErr;
    int  mElapsed, mFracTicks, mTicks, mPeriod;
    bit  eTick, eBit, mApply;

    // Extra cycle owed to interval k: how much floor(k*frac/2^F) advanced on the previous tick
    function automatic int carryFor(input int k, input int f);
        if (k == 0) return 0;
        return ((k * f) >> NB_FRAC) - (((k - 1) * f) >> NB_FRAC);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update on every active edge, mirroring the rules in arithmetic terms
    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mDiv = 651; mFrac = 1; sDiv = 651; sFrac = 1;
            mPend = 0; mErr = 0;
            mElapsed = 0; mFracTicks = 0; mTicks = 0;
            eTick = 0; eBit = 0;
        end else begin
            mApply  = 0;
            eTick   = 0;
            eBit    = 0;
            mPeriod = mDiv + carryFor(mFracTicks, mFrac);
            if (i_sync) begin
                mElapsed = 0; mFracTicks = 0; mTicks = 0;
                mApply = mPend;
            end else if (!i_enable) begin
                if (mPend) begin
                    mApply = 1; mElapsed = 0; mFracTicks = 0;
                end
            end else if (mElapsed == mPeriod - 1) begin
                eTick = 1;
                eBit  = ((mTicks % OVERSAMPLE) == OVERSAMPLE - 1);
                mTicks++;
                mFracTicks++;
                mElapsed = 0;
                if (mPend) begin
                    mApply = 1; mFracTicks = 0;
                end
            end else begin
                mElapsed++;
            end
            if (mApply) begin
                mDiv = sDiv; mFrac = sFrac; mPend = 0;
            end
            if (i_load) begin
                if (int'(i_div_int) >= 2) begin
                    sDiv = int'(i_div_int); sFrac = int'(i_div_frac);
                    mPend = 1; mErr = 0;
                end else begin
                    mErr = 1;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model, away from the active edge
    always @(negedge i_clk) begin
        checkOutput("tick",     int'(o_tick),        int'(eTick));
        checkOutput("bit_tick", int'(o_bit_tick),    int'(eBit));
        checkOutput("tick_idx", int'(o_tick_idx),    mTicks % OVERSAMPLE);
        checkOutput("pending",  int'(o_cfg_pending), int'(mPend));
        checkOutput("cfg_err",  int'(o_cfg_err),     int'(mErr));
    end

    // Stage a divisor and force it active by holding enable low for one extra edge
    task automatic applyStimulus(input int divInt, input int divFrac);
        i_load     = 1'b1;
        i_enable   = 1'b0;
        i_div_int  = NB_DIV'(divInt);
        i_div_frac = NB_FRAC'(divFrac);
        @(negedge i_clk);
        i_load = 1'b0;
        @(negedge i_clk);
        i_enable = 1'b1;
    endtask

    // Count falling edges until a tick is seen, bounded by a cycle budget
    task automatic waitTick(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge i_clk);
            cycles++;
        end while (!o_tick && cycles < budget);
        if (!o_tick) checkOutput("tick_timeout", 0, 1);
    endtask

    int c, span, savedIdx, tickSeen, elapsed;

    initial begin
        i_reset_n  = 1'b0;
        i_enable   = 1'b0;
        i_load     = 1'b0;
        i_div_int  = '0;
        i_div_frac = '0;
        i_sync     = 1'b0;
        repeat (3) @(negedge i_clk);
        checkOutput("reset_idx",     int'(o_tick_idx), 0);
        checkOutput("reset_pending", int'(o_cfg_pending), 0);
        i_reset_n = 1'b1;

        // Integer divisor 4: exact period, bit tick every 16th tick, index walk
        applyStimulus(4, 0);
        for (int i = 1; i <= 32; i++) begin
            waitTick(20, c);
            checkOutput("t1_interval", c, 4);
            checkOutput("t1_idx", int'(o_tick_idx), i % 16);
            checkOutput("t1_bit", int'(o_bit_tick), int'((i % 16) == 0));
        end

        // Fractional 4.5: intervals 4,4,5,4,5... and 20 ticks span about 90 cycles
        applyStimulus(4, 8);
        span = 0;
        for (int i = 1; i <= 20; i++) begin
            waitTick(20, c);
            span += c;
            if (i == 1) checkOutput("t2_first", c, 4);
            if (i == 2) checkOutput("t2_second", c, 4);
            if (i == 3) checkOutput("t2_third", c, 5);
        end
        checkOutput("t2_span_in_range", int'(span >= 89 && span <= 91), 1);

        // Mid-period reload: current interval finishes at old length, then new length
        applyStimulus(10, 0);
        waitTick(30, c);
        checkOutput("t3_base", c, 10);
        repeat (3) @(negedge i_clk);
        i_load = 1'b1; i_div_int = 16'd6; i_div_frac = '0;
        @(negedge i_clk);
        i_load = 1'b0;
        elapsed = 4;
        checkOutput("t3_pending_set", int'(o_cfg_pending), 1);
        waitTick(30, c);
        checkOutput("t3_old_interval", elapsed + c, 10);
        checkOutput("t3_pending_clear", int'(o_cfg_pending), 0);
        waitTick(30, c);
        checkOutput("t3_new_interval", c, 6);

        // Rejected load keeps the old rate; a valid one clears the error
        i_load = 1'b1; i_div_int = 16'd1;
        @(negedge i_clk);
        i_load = 1'b0;
        checkOutput("t4_err_set", int'(o_cfg_err), 1);
        checkOutput("t4_no_pending", int'(o_cfg_pending), 0);
        waitTick(30, c);
        waitTick(30, c);
        checkOutput("t4_rate_kept", c, 6);
        i_load = 1'b1; i_div_int = 16'd3; i_div_frac = '0;
        @(negedge i_clk);
        i_load = 1'b0;
        checkOutput("t4_err_clear", int'(o_cfg_err), 0);
        checkOutput("t4_pending", int'(o_cfg_pending), 1);
        waitTick(30, c);
        waitTick(30, c);
        checkOutput("t4_new_rate", c, 3);

        // Sync at counter 7 / idx 9, then enable low for 20 cycles
        applyStimulus(10, 0);
        for (int i = 0; i < 20; i++) begin
            waitTick(30, c);
            if (o_tick_idx == NB_IDX'(9)) break;
        end
        checkOutput("t5_idx_before", int'(o_tick_idx), 9);
        repeat (7) @(negedge i_clk);
        i_sync = 1'b1;
        @(negedge i_clk);
        i_sync = 1'b0;
        checkOutput("t5_idx_reset", int'(o_tick_idx), 0);
        waitTick(30, c);
        checkOutput("t5_after_sync", c, 10);
        checkOutput("t5_idx_after", int'(o_tick_idx), 1);
        i_enable = 1'b0;
        savedIdx = int'(o_tick_idx);
        tickSeen = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_tick) tickSeen++;
        end
        checkOutput("t5_no_ticks", tickSeen, 0);
        checkOutput("t5_idx_held", int'(o_tick_idx), savedIdx);
        i_enable = 1'b1;

        // Randomized loads, syncs and enable gaps, checked by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge i_clk);
            i_enable   = ($urandom_range(0, 9) != 0);
            i_sync     = ($urandom_range(0, 59) == 0);
            i_load     = ($urandom_range(0, 29) == 0);
            i_div_int  = NB_DIV'($urandom_range(0, 9));
            i_div_frac = NB_FRAC'($urandom_range(0, 15));
        end
        @(negedge i_clk);
        i_enable = 1'b1; i_sync = 1'b0; i_load = 1'b0;

        // Async reset between edges clears outputs at once; defaults give first tick at 651
        i_load = 1'b1; i_div_int = '0;
        @(negedge i_clk);
        i_load = 1'b0;
        checkOutput("t6_err_before", int'(o_cfg_err), 1);
        #2 i_reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_tick", int'(o_tick), 0);
        checkOutput("t6_rst_bit", int'(o_bit_tick), 0);
        checkOutput("t6_rst_idx", int'(o_tick_idx), 0);
        checkOutput("t6_rst_pending", int'(o_cfg_pending), 0);
        checkOutput("t6_rst_err", int'(o_cfg_err), 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_enable  = 1'b1;
        waitTick(700, c);
        checkOutput("t6_default_period", c, 651);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
